// File: rtl/ac_motor_dead_time.sv
// rtl/ac_motor_dead_time.sv - three-phase complementary gate driver with programmable dead time
//
// Purpose:
//   Converts the phase switch commands s1..s3 into complementary high-side and
//   low-side gate signals. Every commutation passes through a dead interval of
//   D = max(dead_time, 1) clk cycles in which both gates of that phase are off.
//   A disable or fault forces every gate off on the next edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       1 = gates may conduct, 0 = all gates off
//   fault        external fault, active high, sampled on clk
//   dead_time    dead interval in clk cycles (0 behaves as 1)
//   s1, s2, s3   phase commands (1 = high side, 0 = low side)
//   gate_h       high-side gates, bit i = phase i+1
//   gate_l       low-side gates, bit i = phase i+1
//   dead_active  phase i is in its dead interval
//   fault_flag   fault shutdown in force
//
// Build option:
//   AC_MOTOR_DEAD_TIME_FAULT_LATCH_EN - when defined, fault_flag latches until
//   an edge with enable = 0 and fault = 0; otherwise it is fault delayed by one
//   cycle.

module ac_motor_dead_time #(
  parameter int unsigned DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fault,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  input  logic                  s1,
  input  logic                  s2,
  input  logic                  s3,
  output logic [2:0]            gate_h,
  output logic [2:0]            gate_l,
  output logic [2:0]            dead_active,
  output logic                  fault_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } phase_state_e;

  phase_state_e          state_q [3];
  phase_state_e          state_d [3];
  logic [DEAD_WIDTH-1:0] cnt_q   [3];
  logic [DEAD_WIDTH-1:0] cnt_d   [3];

  logic [2:0]            s_q,           s_d;
  logic [2:0]            gate_h_q,      gate_h_d;
  logic [2:0]            gate_l_q,      gate_l_d;
  logic [2:0]            dead_active_q, dead_active_d;
  logic                  fault_flag_q,  fault_flag_d;

  logic                  off;
  logic [DEAD_WIDTH-1:0] dead_load;

  // Counter preload is D-1; a programmed 0 is stretched to a 1-cycle interval.
  always_comb begin
    dead_load = '0;
    if (dead_time != '0) begin
      dead_load = dead_time - DEAD_WIDTH'(1);
    end
  end

  // Command register and shutdown qualifier. off uses the next fault_flag so
  // the gates drop on the same edge that raises fault_flag.
  always_comb begin
    s_d = {s3, s2, s1};
`ifdef AC_MOTOR_DEAD_TIME_FAULT_LATCH_EN
    // Set by fault; held until an edge sees enable low with fault clear.
    fault_flag_d = fault | (fault_flag_q & enable);
`else
    fault_flag_d = fault;
`endif
    off = ~enable | fault_flag_d;
  end

  // Per-phase next-state logic. The phase target simply follows s_q while in
  // DEAD, so the exit decision reads s_q directly: a reversal inside the dead
  // interval redirects the exit without restarting the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      if (off) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            state_d[i] = DEAD;
            cnt_d[i]   = dead_load;
          end
          DEAD: begin
            if (cnt_q[i] == '0) begin
              state_d[i] = s_q[i] ? HI : LO;
            end else begin
              cnt_d[i] = cnt_q[i] - DEAD_WIDTH'(1);
            end
          end
          HI: begin
            if (!s_q[i]) begin
              state_d[i] = DEAD;
              cnt_d[i]   = dead_load;
            end
          end
          LO: begin
            if (s_q[i]) begin
              state_d[i] = DEAD;
              cnt_d[i]   = dead_load;
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end

      // Outputs decode the next state so they register on the same edge as
      // the state itself and carry no combinational path to the pins.
      gate_h_d[i]      = (state_d[i] == HI);
      gate_l_d[i]      = (state_d[i] == LO);
      dead_active_d[i] = (state_d[i] == DEAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q           <= '0;
      gate_h_q      <= '0;
      gate_l_q      <= '0;
      dead_active_q <= '0;
      fault_flag_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s_q           <= s_d;
      gate_h_q      <= gate_h_d;
      gate_l_q      <= gate_l_d;
      dead_active_q <= dead_active_d;
      fault_flag_q  <= fault_flag_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign gate_h      = gate_h_q;
  assign gate_l      = gate_l_q;
  assign dead_active = dead_active_q;
  assign fault_flag  = fault_flag_q;

`ifndef SYNTHESIS
  a_no_shoot_through : assert property (
    @(posedge clk) disable iff (!rst_n) ((gate_h_q & gate_l_q) == 3'b000)
  );

  a_dead_gates_off : assert property (
    @(posedge clk) disable iff (!rst_n)
      ((dead_active_q & (gate_h_q | gate_l_q)) == 3'b000)
  );
`endif

endmodule

// File: doc/ac_motor_dead_time.md
Name: ac_motor_dead_time

Overview:
Gate-drive stage placed directly after ac_motor_switch_control. It converts the three phase switch commands (s1, s2, s3) into complementary high-side and low-side gate signals and inserts a programmable dead time on every commutation. It also gives the power stage a synchronous fault/enable shutdown path. A high-side and low-side gate of the same phase are never on together.

Parameters:
DEAD_WIDTH, 8, width of the dead_time port and of the per-phase dead counters

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = gates may conduct; 0 = all gates off
fault  input  1  external fault, active high, sampled synchronously
dead_time  input  DEAD_WIDTH  dead interval in clk cycles; 0 is treated as 1
s1  input  1  phase 1 command (1 = high side, 0 = low side)
s2  input  1  phase 2 command
s3  input  1  phase 3 command
gate_h  output  3  high-side gates, bit i = phase i+1
gate_l  output  3  low-side gates, bit i = phase i+1
dead_active  output  3  phase is currently in its dead interval
fault_flag  output  1  fault shutdown in force

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gate_h = 0, gate_l = 0, dead_active = 0, fault_flag = 0.
  - Input register s_q = 0; all phase FSMs go to IDLE; counters = 0.
- Input path: s1..s3 are registered into s_q every cycle. No other synchronisation is applied, because upstream is on the same clk.
- Shutdown condition: off = !enable | fault_flag_next.
- Per-phase FSM, three independent instances with states IDLE, DEAD, HI, LO. All outputs are registered and decoded from the state.
  - IDLE: gates off. If !off, go to DEAD with target = s_q and cnt = D-1, where D = max(dead_time, 1).
  - DEAD: gates off, dead_active = 1.
    - target is updated to s_q every cycle; a command reversal during DEAD does not restart cnt.
    - cnt decrements each cycle. When cnt == 0, go to HI if target = 1, else LO.
  - HI: gate_h = 1. If s_q == 0, go to DEAD with cnt = D-1.
  - LO: gate_l = 1. If s_q == 1, go to DEAD with cnt = D-1.
  - Any state with off = 1: go to IDLE on the next edge. This overrides all other transitions.
- dead_time is sampled only on entry to DEAD. A change during a dead interval affects the next interval only.
- Timing: command change captured at edge t.
  - Off-going gate falls at edge t+1.
  - On-going gate rises at edge t+1+D.
  - Both gates are low for exactly D cycles.
- Minimum conduction is 1 cycle. A command toggling faster than D+1 cycles produces continuous dead time, never overlap.
- Invariants, checked by assertion: gate_h[i] & gate_l[i] == 0 always; dead_active[i] implies both gates of phase i are low.
- Phases are fully independent. Simultaneous changes on several phases each get their own dead interval.
- fault_flag = registered fault (non-latching build).

Optional Feature:
AC_MOTOR_DEAD_TIME_FAULT_LATCH_EN
- Defined:
  - fault = 1 sets fault_flag at the next edge.
  - fault_flag stays set after fault drops.
  - It clears only on an edge where enable = 0 and fault = 0, or on reset.
  - Gates stay off while fault_flag = 1.
- Undefined: fault_flag follows fault with one cycle of latency, and gates resume through DEAD as soon as fault drops.

Test Plan:
1. Reset: enable=1, phase 1 in HI, assert rst_n=0 mid-cycle -> gate_h = gate_l = 0 immediately, before the next clk edge; after release with enable=1, s=000 -> every phase reaches gate_l = 1 after D+1 cycles.
2. Commutation, dead_time=10: s1 0->1 captured at edge 0 -> gate_l[0] = 0 after edge 1, gate_h[0] = 1 after edge 11, dead_active[0] = 1 for exactly 10 cycles.
3. Reversal during dead, dead_time=10: s1 0->1, then back to 0 after 3 cycles -> no gate_h pulse; gate_l[0] = 1 again at edge 11.
4. dead_time=0: s2 toggles -> exactly 1 cycle with both gates low; no overlap.
5. Fault: phases conducting, fault=1 for 5 cycles -> all gates 0 after 1 edge.
   - Non-latching build: conduction resumes D+1 cycles after fault drops.
   - With FAULT_LATCH_EN: gates stay 0 until enable is pulsed 0 then 1.
6. Full chain (sine_sector -> vector_time -> vector_control -> switch_control -> this block), frequency=0, u_str=4095, dead_time=20, 10^6 cycles -> no overlap violation; every on-edge preceded by >= 20 off cycles.
